// File: rtl/fp_add_pkg.sv
// Shared types and helpers for the FP adder sequencer.
package fp_add_pkg;

  localparam int FP_DATA_W    = 32;
  localparam int FP_MENT_W    = 23;
  localparam int FP_EXPO_W    = 8;
  localparam int FP_ALIGN_MAX = FP_MENT_W + 1;

  // One-hot sequencer states
  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_CMP   = 6'b000010,
    S_ALIGN = 6'b000100,
    S_ADD   = 6'b001000,
    S_NORM  = 6'b010000,
    S_HOLD  = 6'b100000
  } state_e;

  // A word is zero when both exponent and stored mantissa are zero; sign is ignored (+0/-0).
  function automatic logic is_zero(input logic [FP_DATA_W-1:0] w);
    return (w[FP_DATA_W-2 -: FP_EXPO_W] == '0) && (w[FP_MENT_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/align_shift_counter.sv
// Down-counter for the one-bit-per-cycle mantissa alignment.
// The load value is the full exponent difference; it saturates at ALIGN_MAX
// because shifting further than that flushes the significand anyway.
module align_shift_counter #(
  parameter int EXPO_WIDTH = 8,
  parameter int ALIGN_MAX  = 24,
  parameter int CNT_W      = $clog2(ALIGN_MAX + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  load_in,
  input  logic [EXPO_WIDTH-1:0] load_value_in,
  input  logic                  decrement_in,
  output logic                  last_out,
  output logic [CNT_W-1:0]      count_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating load takes priority over decrement; compare is done at full exponent width
  always_comb begin
    cnt_d = cnt_q;
    if (load_in) begin
      if (load_value_in > EXPO_WIDTH'(ALIGN_MAX)) cnt_d = CNT_W'(ALIGN_MAX);
      else                                        cnt_d = CNT_W'(load_value_in);
    end else if (decrement_in && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign last_out  = (cnt_q == CNT_W'(1));
  assign count_out = cnt_q;

endmodule

// File: rtl/fp_add_sequencer.sv
// Multi-cycle sequencer for the single-precision FP adder datapath:
// operand accept, exponent compare, iterative align, add, normalize, result hold.
module fp_add_sequencer
  import fp_add_pkg::*;
#(
  parameter int DATA_WIDTH = FP_DATA_W,
  parameter int MENT_WIDTH = FP_MENT_W,
  parameter int EXPO_WIDTH = FP_EXPO_W,
  parameter int ALIGN_MAX  = MENT_WIDTH + 1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_valid_in,
  output logic                  start_ready_out,
  input  logic [DATA_WIDTH-1:0] opa_in,
  input  logic [DATA_WIDTH-1:0] opb_in,
  input  logic [EXPO_WIDTH-1:0] rshift_in,
  output logic                  op_load_out,
  output logic                  cmp_en_out,
  output logic                  align_en_out,
  output logic                  add_en_out,
  output logic                  norm_en_out,
  output logic                  bypass_out,
  output logic                  bypass_sel_out,
  output logic                  result_valid_out,
  input  logic                  result_ready_in,
  output logic                  busy_out
);

  localparam int CNT_W = $clog2(ALIGN_MAX + 1);

  state_e           state_q, state_d;
  logic             byp_q, byp_d;
  logic             sel_q, sel_d;
  logic             accept;
  logic             cnt_load;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt;
  logic             opa_zero, opb_zero;

  assign opa_zero = is_zero(opa_in);
  assign opb_zero = is_zero(opb_in);

  align_shift_counter #(
    .EXPO_WIDTH (EXPO_WIDTH),
    .ALIGN_MAX  (ALIGN_MAX),
    .CNT_W      (CNT_W)
  ) u_cnt (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .load_in       (cnt_load),
    .load_value_in (rshift_in),
    .decrement_in  (align_en_out),
    .last_out      (cnt_last),
    .count_out     (cnt)
  );

  // Handshake and next-state; ready is masked by reset so nothing is accepted while held
  always_comb begin
    state_d         = state_q;
    byp_d           = byp_q;
    sel_d           = sel_q;
    cnt_load        = 1'b0;
    start_ready_out = 1'b0;
    if (state_q == S_IDLE) start_ready_out = rst_n_in;
    if (state_q == S_HOLD) start_ready_out = rst_n_in & result_ready_in;
    accept = start_valid_in & start_ready_out;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_CMP;
      S_CMP: begin
        // Zero opa wins, so the both-zero case passes opb
        if (opa_zero) begin
          byp_d   = 1'b1;
          sel_d   = 1'b1;
          state_d = S_HOLD;
        end else if (opb_zero) begin
          byp_d   = 1'b1;
          sel_d   = 1'b0;
          state_d = S_HOLD;
        end else if (rshift_in == '0) begin
          state_d = S_ADD;
        end else begin
          cnt_load = 1'b1;
          state_d  = S_ALIGN;
        end
      end
      // Zero count cannot occur after a load, but leaving on it keeps the FSM from sticking
      S_ALIGN: if (cnt_last || (cnt == '0)) state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_HOLD;
      S_HOLD: begin
        if (result_ready_in) begin
          byp_d   = 1'b0;
          sel_d   = 1'b0;
          state_d = accept ? S_CMP : S_IDLE;
        end
      end
      default: begin
        byp_d   = 1'b0;
        sel_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and bypass flag registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      byp_q   <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byp_q   <= byp_d;
      sel_q   <= sel_d;
    end
  end

  // Moore stage enables: one state, one enable
  assign op_load_out      = accept;
  assign cmp_en_out       = (state_q == S_CMP);
  assign align_en_out     = (state_q == S_ALIGN);
  assign add_en_out       = (state_q == S_ADD);
  assign norm_en_out      = (state_q == S_NORM);
  assign result_valid_out = (state_q == S_HOLD);
  assign busy_out         = (state_q != S_IDLE);
  assign bypass_out       = byp_q;
  assign bypass_sel_out   = sel_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Randomized bench for fp_add_sequencer against a transaction-level timing model.
module tb_fp_add_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        start_valid_in = 1'b0;
  logic        result_ready_in = 1'b0;
  logic [31:0] a_drv = '0, b_drv = '0;
  logic [31:0] opa_in, opb_in;
  logic [7:0]  rshift_in;
  logic        start_ready_out, op_load_out, cmp_en_out, align_en_out, add_en_out;
  logic        norm_en_out, bypass_out, bypass_sel_out, result_valid_out, busy_out;
  logic [9:0]  all_o;

  int n_chk = 0;
  int n_err = 0;

  fp_add_sequencer dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .start_valid_in   (start_valid_in),
    .start_ready_out  (start_ready_out),
    .opa_in           (opa_in),
    .opb_in           (opb_in),
    .rshift_in        (rshift_in),
    .op_load_out      (op_load_out),
    .cmp_en_out       (cmp_en_out),
    .align_en_out     (align_en_out),
    .add_en_out       (add_en_out),
    .norm_en_out      (norm_en_out),
    .bypass_out       (bypass_out),
    .bypass_sel_out   (bypass_sel_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .busy_out         (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // Operand register loaded by the sequencer, and the control unit's exponent difference
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      opa_in <= '0;
      opb_in <= '0;
    end else if (op_load_out) begin
      opa_in <= a_drv;
      opb_in <= b_drv;
    end
  end
  assign rshift_in = (opa_in[30:23] > opb_in[30:23]) ? opa_in[30:23] - opb_in[30:23]
                                                     : opb_in[30:23] - opa_in[30:23];

  assign all_o = {start_ready_out, op_load_out, cmp_en_out, align_en_out, add_en_out,
                  norm_en_out, bypass_out, bypass_sel_out, result_valid_out, busy_out};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected behaviour of one operation from the operand words alone
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output bit byp, output bit sel, output int k, output int lat);
    int ea, eb, r;
    bit za, zb;
    za  = (a[30:0] == 31'd0);
    zb  = (b[30:0] == 31'd0);
    byp = za | zb;
    sel = za;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    r   = (ea > eb) ? ea - eb : eb - ea;
    k   = byp ? 0 : ((r > 24) ? 24 : r);
    lat = byp ? 2 : k + 4;
  endtask

  // Called at a negedge; returns at the negedge of cycle 1 after the accept edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int w;
    a_drv = a;
    b_drv = b;
    start_valid_in = 1'b1;
    #1;
    w = 0;
    while (!start_ready_out && w < 50) begin
      @(negedge clk_in); #1;
      w++;
    end
    chk("accept_ready", start_ready_out, 1);
    chk("accept_op_load", op_load_out, 1);
    @(posedge clk_in);
    @(negedge clk_in);
    start_valid_in  = 1'b0;
    result_ready_in = 1'b0;
  endtask

  // Watches one operation from cycle 1 until result_valid; returns at the first valid negedge
  task automatic follow(input logic [31:0] a, input logic [31:0] b);
    bit byp, sel;
    int k, lat, c, vcyc, n_cmp, n_al, n_add, n_norm, f_al, f_add, f_cmp;
    model(a, b, byp, sel, k, lat);
    vcyc = 0; n_cmp = 0; n_al = 0; n_add = 0; n_norm = 0; f_al = 0; f_add = 0; f_cmp = 0;
    c = 1;
    while (c <= 60) begin
      chk("enables_exclusive", (int'(cmp_en_out) + int'(align_en_out) + int'(add_en_out) +
                                int'(norm_en_out) + int'(result_valid_out)) > 1, 0);
      if (cmp_en_out)   begin n_cmp++;  if (f_cmp == 0) f_cmp = c; end
      if (align_en_out) begin n_al++;   if (f_al == 0)  f_al = c;  end
      if (add_en_out)   begin n_add++;  if (f_add == 0) f_add = c; end
      if (norm_en_out)  n_norm++;
      if (result_valid_out) begin
        vcyc = c;
        break;
      end
      chk("busy_in_flight", busy_out, 1);
      chk("ready_in_flight", start_ready_out, 0);
      @(negedge clk_in);
      c++;
    end
    chk("valid_latency", vcyc, lat);
    chk("cmp_cycle", f_cmp, 1);
    chk("cmp_count", n_cmp, 1);
    chk("align_count", n_al, k);
    chk("align_first", f_al, (k > 0) ? 2 : 0);
    chk("add_count", n_add, byp ? 0 : 1);
    chk("add_cycle", f_add, byp ? 0 : k + 2);
    chk("norm_count", n_norm, byp ? 0 : 1);
    chk("bypass", bypass_out, byp);
    chk("bypass_sel", bypass_sel_out, byp ? sel : 1'b0);
  endtask

  // Backpressure: result must stay valid and no new operand may be taken
  task automatic hold_valid(input int h);
    repeat (h) begin
      @(negedge clk_in);
      chk("hold_valid", result_valid_out, 1);
      chk("hold_ready", start_ready_out, 0);
    end
  endtask

  task automatic release_result();
    result_ready_in = 1'b1;
    @(negedge clk_in);
    result_ready_in = 1'b0;
    chk("release_valid", result_valid_out, 0);
    chk("release_busy", busy_out, 0);
    chk("release_bypass", {bypass_out, bypass_sel_out}, 0);
    chk("release_ready", start_ready_out, 1);
  endtask

  initial begin
    logic [31:0] a, b;
    // Reset state
    repeat (3) @(negedge clk_in);
    chk("reset_outputs", all_o, 0);
    rst_n_in = 1'b1;
    #1;
    chk("post_reset_outputs", all_o, 10'b10_0000_0000);
    @(negedge clk_in);
    chk("idle_outputs", all_o, 10'b10_0000_0000);

    // Directed cases: equal exponents, small shift, saturated shift, zero operands
    issue(32'h3F800000, 32'h3F800000); follow(32'h3F800000, 32'h3F800000); release_result();
    issue(32'h41200000, 32'h3F800000); follow(32'h41200000, 32'h3F800000); release_result();
    issue(32'h7F000000, 32'h3F800000); follow(32'h7F000000, 32'h3F800000);
    hold_valid(1); release_result();
    issue(32'h00000000, 32'h40400000); follow(32'h00000000, 32'h40400000); release_result();
    issue(32'h40400000, 32'h80000000); follow(32'h40400000, 32'h80000000); release_result();
    issue(32'h80000000, 32'h00000000); follow(32'h80000000, 32'h00000000); release_result();

    // Backpressure then back-to-back accept on the releasing edge
    issue(32'h41200000, 32'h3F800000); follow(32'h41200000, 32'h3F800000);
    hold_valid(5);
    result_ready_in = 1'b1;
    issue(32'h3F800000, 32'h3F800000);
    chk("b2b_cmp", cmp_en_out, 1);
    chk("b2b_bypass_cleared", bypass_out, 0);
    follow(32'h3F800000, 32'h3F800000); release_result();

    // Reset during ALIGN discards the operation
    issue(32'h41200000, 32'h3F800000);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("mid_align", align_en_out, 1);
    rst_n_in = 1'b0;
    #1;
    chk("mid_reset_outputs", all_o, 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (8) begin
      @(negedge clk_in);
      chk("no_valid_after_reset", {result_valid_out, busy_out}, 0);
    end

    // Random operations with random backpressure and back-to-back issue
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        a[30:23] = 8'($urandom_range(100, 150));
        b[30:23] = 8'($urandom_range(100, 150));
      end
      if ($urandom_range(0, 7) == 0) a[30:0] = '0;
      if ($urandom_range(0, 7) == 0) b[30:0] = '0;
      issue(a, b);
      follow(a, b);
      hold_valid($urandom_range(0, 3));
      if (i < 39 && $urandom_range(0, 1) == 1) result_ready_in = 1'b1;
      else release_result();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
